// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: op codes,
// FSM encoding and the legal-op decoder.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    function automatic logic is_legal_op(
        input logic [2:0] ctrl
    );
        logic ok;
        case (ctrl)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_SLT: ok = 1'b1;
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// Round-robin grant: first set request at or
// after rr_ptr, wrapping modulo NUM_REQ.
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among NUM_REQ requesters
// with round-robin grant and a one-deep response slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_src_A,
    input  logic [NUM_REQ*WIDTH-1:0] req_src_B,
    input  logic [NUM_REQ*3-1:0]     req_control,
    output logic [WIDTH-1:0]         alu_src_A,
    output logic [WIDTH-1:0]         alu_src_B,
    output logic [2:0]               alu_control,
    input  logic [WIDTH-1:0]         alu_result,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_illegal,
    output logic [ID_W-1:0]          rsp_id,
    output logic [15:0]              op_count
);

    state_t              state;
    state_t              state_nx;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     ptr_nx;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                any;
    logic                accept;
    logic                issue;
    logic                legal;
    logic [2:0]          sel_ctrl;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign accept = (state == S_RESP)
                  && rsp_ready[rsp_id];
    assign issue  = ((state == S_IDLE) || accept)
                  && any;

    assign req_ready = issue ? grant : '0;
    assign sel_ctrl  = req_control[grant_idx*3 +: 3];
    assign legal     = is_legal_op(sel_ctrl);

    assign ptr_nx = (grant_idx == ID_W'(NUM_REQ-1))
                  ? '0
                  : grant_idx + 1'b1;

    always_comb begin
        alu_src_A   = '0;
        alu_src_B   = '0;
        alu_control = OP_ADD;
        state_nx    = state;
        if (issue) begin
            alu_src_A   = req_src_A[grant_idx*WIDTH +: WIDTH];
            alu_src_B   = req_src_B[grant_idx*WIDTH +: WIDTH];
            alu_control = sel_ctrl;
            state_nx    = S_RESP;
        end else if (accept) begin
            state_nx    = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_id      <= '0;
            op_count    <= '0;
        end else begin
            state <= state_nx;
            if (accept && op_count != 16'hFFFF)
                op_count <= op_count + 16'd1;
            // Illegal codes never expose the ALU's output.
            if (issue) begin
                rr_ptr      <= ptr_nx;
                rsp_valid   <= grant;
                rsp_id      <= grant_idx;
                rsp_illegal <= !legal;
                rsp_result  <= legal ? alu_result : '0;
                rsp_zero    <= legal ? (alu_result == '0)
                                     : 1'b1;
            end else if (accept) begin
                rsp_valid   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random bench for alu_arbiter against
// a transaction-level model of the arbiter.
module tb_alu_arbiter;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_src_A;
    logic [63:0] req_src_B;
    logic [5:0]  req_control;
    logic [31:0] alu_src_A;
    logic [31:0] alu_src_B;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;
    logic [0:0]  rsp_id;
    logic [15:0] op_count;

    alu_arbiter #(
        .NUM_REQ (2),
        .WIDTH   (32),
        .ID_W    (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src_A   (req_src_A),
        .req_src_B   (req_src_B),
        .req_control (req_control),
        .alu_src_A   (alu_src_A),
        .alu_src_B   (alu_src_B),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .rsp_id      (rsp_id),
        .op_count    (op_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] ext_alu(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  op
    );
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_result = ext_alu(alu_src_A, alu_src_B, alu_control);

    int passed = 0;
    int total  = 0;

    logic [1:0]  tv;
    logic [1:0]  tr;
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    logic [2:0]  tc [2];

    bit          m_valid = 0;
    int          m_id    = 0;
    logic [31:0] m_res   = 0;
    bit          m_zero  = 0;
    bit          m_ill   = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        int  g;
        bit  iss;
        bit  acc;
        bit  legal;
        req_valid   = tv;
        rsp_ready   = tr;
        req_src_A   = {ta[1], ta[0]};
        req_src_B   = {tb[1], tb[0]};
        req_control = {tc[1], tc[0]};
        @(negedge clock);
        chk("rsp_valid", 32'(rsp_valid), m_valid ? (32'd1 << m_id) : 32'd0);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        chk("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        acc = m_valid && tr[m_id];
        iss = (!m_valid || acc) && (tv != 2'b00);
        g = tv[m_ptr] ? m_ptr : (m_ptr + 1) % 2;
        chk("req_ready", 32'(req_ready), iss ? (32'd1 << g) : 32'd0);
        chk("alu_src_A", alu_src_A, iss ? ta[g] : 32'd0);
        chk("alu_src_B", alu_src_B, iss ? tb[g] : 32'd0);
        chk("alu_control", 32'(alu_control), iss ? 32'(tc[g]) : 32'd0);
        if (!reset_n) begin
            m_valid = 0; m_id = 0; m_res = 0;
            m_zero = 0; m_ill = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (acc && m_cnt < 65535) m_cnt++;
            if (iss) begin
                legal = tc[g] inside {3'b000, 3'b001, 3'b010,
                                      3'b011, 3'b101};
                m_valid = 1;
                m_id    = g;
                m_ill   = !legal;
                m_res   = legal ? ext_alu(ta[g], tb[g], tc[g]) : 32'd0;
                m_zero  = (m_res == 32'd0);
                m_ptr   = (g + 1) % 2;
            end else if (acc) begin
                m_valid = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        tv = 2'b00; tr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ta[i] = '0; tb[i] = '0; tc[i] = '0;
        end
        step();
        step();
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_count", 32'(op_count), 32'd0);
        reset_n = 1'b1;

        // single op
        tv = 2'b01; ta[0] = 5; tb[0] = 7; tc[0] = 3'b000;
        step();
        tv = 2'b00;
        step();
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_result", rsp_result, 32'd12);
        chk("t1_zero", 32'(rsp_zero), 32'd0);
        tr = 2'b01;
        step();
        tr = 2'b00;

        // contention from reset
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        tv = 2'b11;
        ta[0] = 3; tb[0] = 3; tc[0] = 3'b001;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 2; tc[1] = 3'b101;
        step();
        chk("t2_id0", 32'(rsp_id), 32'd0);
        chk("t2_zero0", 32'(rsp_zero), 32'd1);
        tv = 2'b10; tr = 2'b01;
        step();
        chk("t2_id1", 32'(rsp_id), 32'd1);
        chk("t2_res1", rsp_result, 32'd1);
        tv = 2'b11; tr = 2'b10;
        step();
        chk("t2_wrap", 32'(rsp_id), 32'd0);
        tv = 2'b00; tr = 2'b01;
        step();

        // backpressure
        tv = 2'b10; ta[1] = 100; tb[1] = 23; tc[1] = 3'b011;
        tr = 2'b00;
        step();
        tv = 2'b11; ta[0] = 40; tb[0] = 2; tc[0] = 3'b000;
        tr = 2'b01;
        for (int i = 0; i < 4; i++) step();
        chk("t3_hold", rsp_result, 32'd119);
        tr = 2'b10;
        step();
        chk("t3_b2b_id", 32'(rsp_id), 32'd0);
        chk("t3_b2b_res", rsp_result, 32'd42);
        tv = 2'b00; tr = 2'b01;
        step();

        // illegal op
        tv = 2'b10; ta[1] = 9; tb[1] = 9; tc[1] = 3'b110;
        tr = 2'b00;
        step();
        chk("t4_ill", 32'(rsp_illegal), 32'd1);
        chk("t4_res", rsp_result, 32'd0);
        chk("t4_id", 32'(rsp_id), 32'd1);
        tv = 2'b00; tr = 2'b10;
        step();

        // reset while holding a response
        tv = 2'b01; tr = 2'b00;
        step();
        reset_n = 1'b0; tv = 2'b00;
        step();
        chk("t5_valid", 32'(rsp_valid), 32'd0);
        chk("t5_count", 32'(op_count), 32'd0);
        reset_n = 1'b1; tv = 2'b11; tc[1] = 3'b000;
        step();
        chk("t5_ptr", 32'(rsp_id), 32'd0);

        // throughput
        reset_n = 1'b0; tv = 2'b00;
        step();
        reset_n = 1'b1;
        tv = 2'b01; tr = 2'b01; tc[0] = 3'b000;
        for (int i = 0; i < 10; i++) begin
            ta[0] = i; tb[0] = 1;
            step();
            chk("t6_valid", 32'(rsp_valid), 32'd1);
        end
        tv = 2'b00;
        step();
        chk("t6_count", 32'(op_count), 32'd10);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            tv = 2'($urandom_range(0, 3));
            tr = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                ta[i] = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 2))
                                                  : $urandom;
                tb[i] = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 2))
                                                  : $urandom;
                tc[i] = 3'($urandom_range(0, 7));
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
